// File: rtl/gate_tb_pkg.sv
// Shared types for the gate truth-table sweeper: FSM states and vector-count helper.
package gate_tb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIN  = 2'd2
   } sweep_state_t;

   function automatic int num_vec(input int n_in);
      return 1 << n_in;
   endfunction

endpackage

// File: rtl/gate_truth_sweeper_if.sv
// Stimulus/response bundle between the sweeper (master) and the bench or gate side (slave).
interface gate_truth_sweeper_if #(
   parameter int N_IN = 2
);
   logic            start;
   logic            Y;
   logic [N_IN-1:0] VEC;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_count;
   logic [N_IN-1:0] fail_idx;

   modport master (
      input  start,
      input  Y,
      output VEC,
      output busy,
      output done,
      output pass,
      output err_count,
      output fail_idx
   );

   modport slave (
      output start,
      output Y,
      input  VEC,
      input  busy,
      input  done,
      input  pass,
      input  err_count,
      input  fail_idx
   );
endinterface

// File: rtl/gate_truth_sweeper.sv
// Sweeps all 2**N_IN input vectors, holding each SETTLE+1 cycles, and tallies Y against TRUTH.
// Verdict one cycle after the last sample; start is ignored while a sweep is running (no queuing).
module gate_truth_sweeper
   import gate_tb_pkg::*;
#(
   parameter int                       N_IN   = 2,
   parameter int                       SETTLE = 1,
   parameter logic [(2**N_IN)-1:0]     TRUTH  = 4'b1000
) (
   input  logic                clk,
   input  logic                rst,
   gate_truth_sweeper_if.master bus
);

   localparam logic [N_IN-1:0] VEC_LAST = N_IN'(num_vec(N_IN) - 1);
   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

   sweep_state_t    state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [3:0]      cnt_q, cnt_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] fidx_q, fidx_d;
   logic            ff_q, ff_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;

   logic            mismatch;
   logic [N_IN:0]   err_next;

   assign mismatch = (bus.Y != TRUTH[vec_q]);
   assign err_next = err_q + (N_IN+1)'(mismatch);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         vec_q   <= '0;
         cnt_q   <= '0;
         err_q   <= '0;
         fidx_q  <= '0;
         ff_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
         fidx_q  <= fidx_d;
         ff_q    <= ff_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
      end
   end

   always_comb begin
      state_d = state_q;
      vec_d   = vec_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      fidx_d  = fidx_q;
      ff_d    = ff_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      pass_d  = pass_q;

      unique case (state_q)
         IDLE: begin
            if (bus.start) begin
               vec_d   = '0;
               cnt_d   = '0;
               err_d   = '0;
               fidx_d  = '0;
               ff_d    = 1'b0;
               pass_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = RUN;
            end
         end

         RUN: begin
            if (cnt_q != SETTLE_C) begin
               cnt_d = cnt_q + 4'd1;
            end else begin
               err_d = err_next;
               if (mismatch && !ff_q) begin
                  fidx_d = vec_q;
                  ff_d   = 1'b1;
               end
               // Verdict uses err_next so the final sample is already counted.
               if (vec_q == VEC_LAST) begin
                  vec_d   = '0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  pass_d  = (err_next == '0);
                  state_d = FIN;
               end else begin
                  vec_d = vec_q + 1'b1;
                  cnt_d = '0;
               end
            end
         end

         FIN: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.VEC       = vec_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.pass      = pass_q;
   assign bus.err_count = err_q;
   assign bus.fail_idx  = fidx_q;

endmodule
